// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension stage: extension modes and
// the state encoding of the two-entry skid buffer.
package imm_ext_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SEXT = 2'b00;
  localparam mode_t MODE_ZEXT = 2'b01;
  localparam mode_t MODE_LUI  = 2'b10;
  localparam mode_t MODE_BR   = 2'b11;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic two-entry valid/ready skid buffer. The output register holds the
// head entry, the skid register the second; both handshake flags are flops.
module skid_buf2
  import imm_ext_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q, state_nx;
  logic         ready_q, valid_q;
  logic [W-1:0] out_q, skid_q;
  logic         accept, emit;
  logic         load_out, load_skid, out_from_skid;

  assign accept = in_valid && (state_q != FULL);
  assign emit   = out_ready && (state_q != EMPTY);

  // Next-state and datapath steering.
  always_comb begin
    state_nx      = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_nx = ONE;
          load_out = 1'b1;
        end
      end
      ONE: begin
        if (accept && !emit) begin
          state_nx  = FULL;
          load_skid = 1'b1;
        end else if (accept && emit) begin
          load_out = 1'b1;
        end else if (emit) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_nx      = ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Handshake flags are precomputed from the next state so the ports are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_nx;
      ready_q <= (state_nx != FULL);
      valid_q <= (state_nx != EMPTY);
      if (load_out) out_q <= out_from_skid ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extension for the MIPS datapath: extends the raw
// immediate at accept time and buffers {operand, tag} in a two-entry skid.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  mode_t            in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PAD_W = OUT_W - IN_W;
  localparam int unsigned BUF_W = OUT_W + TAG_W;

  if (IN_W < 2) begin : g_bad_in_w
    $error("imm_extend_pipe: IN_W must be at least 2");
  end
  if (OUT_W < IN_W + 2) begin : g_bad_out_w
    $error("imm_extend_pipe: OUT_W must be at least IN_W + 2");
  end

  logic [OUT_W-1:0] sext, ext;
  logic [BUF_W-1:0] buf_out;

  assign sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  // Branch offsets drop the two top sign copies; the width margin makes that lossless.
  always_comb begin
    ext = sext;
    case (in_mode)
      MODE_SEXT: ext = sext;
      MODE_ZEXT: ext = {{PAD_W{1'b0}}, in_imm};
      MODE_LUI:  ext = {in_imm, {PAD_W{1'b0}}};
      default:   ext = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

  skid_buf2 #(.W(BUF_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ext, in_tag}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data = buf_out[BUF_W-1:TAG_W];
  assign out_tag  = buf_out[TAG_W-1:0];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default 16->32 instance plus a 12->24 variant.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_imm;
  mode_t       a_in_mode;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [31:0] a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [11:0] b_in_imm;
  mode_t       b_in_mode;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [23:0] b_out_data;

  int errors = 0;
  int checks = 0;

  imm_extend_pipe u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_imm(a_in_imm),
    .in_mode(a_in_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(24), .TAG_W(5)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_imm(b_in_imm),
    .in_mode(b_in_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] imm, input mode_t m, input logic [4:0] t);
    a_in_valid = v;
    a_in_imm   = imm;
    a_in_mode  = m;
    a_in_tag   = t;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(1'b0, 16'h0, MODE_SEXT, 5'd0);
    a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = MODE_SEXT; b_in_tag = '0;
    b_out_ready = 1'b1;

    #12;
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_out_tag", 64'(a_out_tag), 64'd0);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    rst_n = 1'b1;

    // Mode sweep with out_ready high; each result visible one edge after accept.
    drive_a(1'b1, 16'h8000, MODE_SEXT, 5'd3);
    step();
    chk("sext_valid", 64'(a_out_valid), 64'd1);
    chk("sext_data", 64'(a_out_data), 64'hFFFF8000);
    chk("sext_tag", 64'(a_out_tag), 64'd3);
    drive_a(1'b1, 16'h8000, MODE_ZEXT, 5'd4);
    step();
    chk("zext_data", 64'(a_out_data), 64'h00008000);
    chk("zext_tag", 64'(a_out_tag), 64'd4);
    drive_a(1'b1, 16'h1234, MODE_LUI, 5'd5);
    step();
    chk("lui_data", 64'(a_out_data), 64'h12340000);
    chk("lui_tag", 64'(a_out_tag), 64'd5);
    drive_a(1'b1, 16'hFFFF, MODE_BR, 5'd6);
    step();
    chk("br_data", 64'(a_out_data), 64'hFFFFFFFC);
    chk("br_tag", 64'(a_out_tag), 64'd6);
    drive_a(1'b0, 16'h0, MODE_SEXT, 5'd0);
    step();
    chk("sweep_drain", 64'(a_out_valid), 64'd0);

    // Streaming: accept and emit on every edge, ONE state throughout.
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 16'(i * 16'h0101), MODE_ZEXT, 5'(i + 8));
      chk($sformatf("stream_ready_%0d", i), 64'(a_in_ready), 64'd1);
      step();
      chk($sformatf("stream_valid_%0d", i), 64'(a_out_valid), 64'd1);
      chk($sformatf("stream_data_%0d", i), 64'(a_out_data), 64'(i * 32'h0101));
      chk($sformatf("stream_tag_%0d", i), 64'(a_out_tag), 64'(i + 8));
    end
    drive_a(1'b0, 16'h0, MODE_SEXT, 5'd0);
    step();
    chk("stream_drain", 64'(a_out_valid), 64'd0);

    // Backpressure: fill both entries, hold the third, then release in order.
    a_out_ready = 1'b0;
    drive_a(1'b1, 16'h0011, MODE_ZEXT, 5'd1);
    step();
    chk("bp1_ready", 64'(a_in_ready), 64'd1);
    chk("bp1_data", 64'(a_out_data), 64'h11);
    drive_a(1'b1, 16'h0022, MODE_ZEXT, 5'd2);
    step();
    chk("bp2_ready", 64'(a_in_ready), 64'd0);
    chk("bp2_data", 64'(a_out_data), 64'h11);
    chk("bp2_tag", 64'(a_out_tag), 64'd1);
    drive_a(1'b1, 16'h0033, MODE_ZEXT, 5'd3);
    step();
    chk("bp3_ready", 64'(a_in_ready), 64'd0);
    chk("bp3_hold_data", 64'(a_out_data), 64'h11);
    step();
    chk("bp3_hold_tag", 64'(a_out_tag), 64'd1);
    a_out_ready = 1'b1;
    step();
    chk("bp_rel_ready", 64'(a_in_ready), 64'd1);
    chk("bp_rel2_data", 64'(a_out_data), 64'h22);
    chk("bp_rel2_tag", 64'(a_out_tag), 64'd2);
    step();
    drive_a(1'b0, 16'h0, MODE_SEXT, 5'd0);
    chk("bp_rel3_data", 64'(a_out_data), 64'h33);
    chk("bp_rel3_tag", 64'(a_out_tag), 64'd3);
    step();
    chk("bp_drain", 64'(a_out_valid), 64'd0);

    // Asynchronous reset while FULL: clears immediately, stale entries never return.
    a_out_ready = 1'b0;
    drive_a(1'b1, 16'h0077, MODE_ZEXT, 5'd7);
    step();
    drive_a(1'b1, 16'h0088, MODE_ZEXT, 5'd8);
    step();
    drive_a(1'b0, 16'h0, MODE_SEXT, 5'd0);
    chk("full_before_rst", 64'(a_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(a_out_valid), 64'd0);
    chk("arst_out_data", 64'(a_out_data), 64'd0);
    chk("arst_out_tag", 64'(a_out_tag), 64'd0);
    chk("arst_in_ready", 64'(a_in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    step();
    chk("post_rst_idle1", 64'(a_out_valid), 64'd0);
    step();
    chk("post_rst_idle2", 64'(a_out_valid), 64'd0);
    drive_a(1'b1, 16'h0099, MODE_ZEXT, 5'd9);
    step();
    drive_a(1'b0, 16'h0, MODE_SEXT, 5'd0);
    chk("post_rst_data", 64'(a_out_data), 64'h99);
    chk("post_rst_tag", 64'(a_out_tag), 64'd9);

    // Parameter variant 12 -> 24.
    b_in_valid = 1'b1; b_in_imm = 12'h800; b_in_mode = MODE_BR; b_in_tag = 5'd17;
    step();
    chk("b_br_data", 64'(b_out_data), 64'hFFE000);
    chk("b_br_tag", 64'(b_out_tag), 64'd17);
    b_in_mode = MODE_LUI; b_in_tag = 5'd18;
    step();
    chk("b_lui_data", 64'(b_out_data), 64'h800000);
    b_in_mode = MODE_SEXT; b_in_tag = 5'd19;
    step();
    chk("b_sext_data", 64'(b_out_data), 64'hFFF800);
    b_in_valid = 1'b0;
    step();
    chk("b_drain", 64'(b_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
